// File: rtl/vsa_mem_if.sv
// vsa_mem_if: processor-side bus of the VSA memory responder.
// Groups the instruction fetch port, the data port and the program load port.
// The master side is the processor plus loader; the slave side is vsa_mem.
interface vsa_mem_if;
  // Instruction fetch port
  logic [4:0]  PC;
  logic [11:0] instruction;
  // Data port
  logic [4:0]  ALUOutput;
  logic [4:0]  datain;
  logic [4:0]  dataout;
  logic        wr;
  // Program load port and status
  logic        ld_valid;
  logic        ld_ready;
  logic [11:0] ld_data;
  logic        ld_last;
  logic        run;
  logic        wr_err;

  modport master (
    output PC, ALUOutput, dataout, wr, ld_valid, ld_data, ld_last,
    input  instruction, datain, ld_ready, run, wr_err
  );

  modport slave (
    input  PC, ALUOutput, dataout, wr, ld_valid, ld_data, ld_last,
    output instruction, datain, ld_ready, run, wr_err
  );
endinterface

// File: rtl/vsa_mem.sv
// vsa_mem: zero-wait-state memory responder for the 12-bit VSA processor.
// After reset it accepts a program image over a valid/ready load port (LOAD),
// then serves instruction fetches and data reads/writes (RUN) until reset.
// Optional feature: define VSA_MEM_WRCOUNT_EN to add a saturating 8-bit
// counter of accepted RUN-mode writes on output wr_count.
module vsa_mem #(
  parameter int IWORDS = 16,
  parameter int DWORDS = 32
) (
  input logic      clock,
  input logic      reset_n,
  vsa_mem_if.slave bus
`ifdef VSA_MEM_WRCOUNT_EN
  ,
  output logic [7:0] wr_count
`endif
);

  localparam int LP_W = $clog2(IWORDS);

  typedef enum logic {LOAD, RUN} stateType;

  stateType        state;
  stateType        stateNext;
  logic [LP_W-1:0] lp;
  logic [11:0]     imem [IWORDS];
  logic [4:0]      dmem [DWORDS];
  logic            wrErr;
  logic            ldReady;
  logic            runMode;
  logic            handshake;
  logic            lastWord;

  // PC advances by 2, so its low bit never selects a word.
  logic unusedPcBit;
  assign unusedPcBit = bus.PC[0];

  // Next-state decode and mode outputs.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    stateNext = state;
    ldReady   = 1'b0;
    runMode   = 1'b0;
    handshake = 1'b0;
    lastWord  = 1'b0;
    case (state)
      LOAD: begin
        // Hold off the loader during reset so no word is lost at the reset edge.
        ldReady   = reset_n;
        handshake = bus.ld_valid & ldReady;
        lastWord  = handshake & (bus.ld_last | (lp == LP_W'(IWORDS - 1)));
        if (lastWord) stateNext = RUN;
      end
      RUN: runMode = 1'b1;
      default: stateNext = LOAD;
    endcase
  end

  // State register; RUN is left only through reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= LOAD;
    else          state <= stateNext;
  end

  // Load pointer; it stops on the final word instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n)                   lp <= '0;
    else if (handshake && !lastWord) lp <= lp + 1'b1;
  end

  // Instruction memory: written only by load handshakes.
  // NOTE: both memories are cleared by reset because unloaded words must read
  // as 0 and a reset mid-load must discard the partial image; this forces a
  // flop-based store rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < IWORDS; i++) imem[i] <= '0;
    end else if (handshake) begin
      imem[lp] <= bus.ld_data;
    end
  end

  // Data memory: written at the edge where wr is sampled, only in RUN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DWORDS; i++) dmem[i] <= '0;
    end else if (runMode && bus.wr) begin
      dmem[bus.ALUOutput] <= bus.dataout;
    end
  end

  // Sticky flag for writes attempted before the image is loaded.
  always_ff @(posedge clock) begin
    if (!reset_n)                     wrErr <= 1'b0;
    else if (state == LOAD && bus.wr) wrErr <= 1'b1;
  end

`ifdef VSA_MEM_WRCOUNT_EN
  // Saturating count of accepted RUN writes; dropped LOAD writes are ignored.
  always_ff @(posedge clock) begin
    if (!reset_n)                                  wr_count <= '0;
    else if (runMode && bus.wr && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
  end
`endif

  // Zero-latency reads; LOAD returns 12'h000 (LW into R0) so a free-running
  // processor steps through PC without side effects.
  assign bus.instruction = runMode ? imem[bus.PC[4:1]] : 12'h000;
  assign bus.datain      = runMode ? dmem[bus.ALUOutput] : 5'd0;
  assign bus.ld_ready    = ldReady;
  assign bus.run         = runMode;
  assign bus.wr_err      = wrErr;

endmodule

// File: tb/tb_vsa_mem.sv
// tb_vsa_mem: directed self-checking bench for vsa_mem.
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next rising edge. Define VSA_MEM_WRCOUNT_EN to also exercise wr_count.
module tb_vsa_mem;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  vsa_mem_if bus ();

`ifdef VSA_MEM_WRCOUNT_EN
  logic [7:0] wrCount;
`endif

  vsa_mem dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef VSA_MEM_WRCOUNT_EN
    ,
    .wr_count(wrCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n          = 1'b0;
    bus.PC           = '0;
    bus.ALUOutput    = '0;
    bus.dataout      = '0;
    bus.wr           = 1'b0;
    bus.ld_valid     = 1'b0;
    bus.ld_data      = '0;
    bus.ld_last      = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ld_ready", 32'(bus.ld_ready), 0);
    check("rst_run", 32'(bus.run), 0);
    check("rst_instruction", 32'(bus.instruction), 0);
    check("rst_datain", 32'(bus.datain), 0);
    check("rst_wr_err", 32'(bus.wr_err), 0);
`ifdef VSA_MEM_WRCOUNT_EN
    check("rst_wr_count", 32'(wrCount), 0);
`endif
    reset_n = 1'b1;
    #1;
    check("ld_ready_after_rst", 32'(bus.ld_ready), 1);

    // Load three words, last one flagged
    bus.ld_valid = 1'b1;
    bus.ld_data  = 12'h801;
    tick();
    bus.PC = 5'd0;
    #1;
    check("load_instr_forced0", 32'(bus.instruction), 0);
    bus.ld_data = 12'h611;
    tick();
    bus.ld_data = 12'h283;
    bus.ld_last = 1'b1;
    #1;
    check("run_before_last", 32'(bus.run), 0);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    #1;
    check("run_after_last", 32'(bus.run), 1);
    check("ld_ready_in_run", 32'(bus.ld_ready), 0);
    check("fetch_pc0", 32'(bus.instruction), 32'h801);
    bus.PC = 5'd2; #1;
    check("fetch_pc2", 32'(bus.instruction), 32'h611);
    bus.PC = 5'd4; #1;
    check("fetch_pc4", 32'(bus.instruction), 32'h283);
    bus.PC = 5'd5; #1;
    check("fetch_pc5_lsb_ignored", 32'(bus.instruction), 32'h283);
    bus.PC = 5'd6; #1;
    check("fetch_pc6_unloaded", 32'(bus.instruction), 32'h000);

    // RUN write: old value during the write cycle, new value afterwards
    bus.wr        = 1'b1;
    bus.ALUOutput = 5'd9;
    bus.dataout   = 5'd21;
    #1;
    check("wr_cycle_old_value", 32'(bus.datain), 0);
    tick();
    bus.wr = 1'b0;
    #1;
    check("read_after_write", 32'(bus.datain), 21);
    bus.ALUOutput = 5'd10; #1;
    check("neighbour_untouched", 32'(bus.datain), 0);
    check("no_wr_err_in_run", 32'(bus.wr_err), 0);
`ifdef VSA_MEM_WRCOUNT_EN
    check("wr_count_one", 32'(wrCount), 1);
`endif

    // Reset from RUN clears memories and returns to LOAD
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("run_cleared_by_rst", 32'(bus.run), 0);
    check("ld_ready_reload", 32'(bus.ld_ready), 1);

    // Write during LOAD is dropped and sets wr_err
    bus.wr        = 1'b1;
    bus.ALUOutput = 5'd4;
    bus.dataout   = 5'd7;
    tick();
    bus.wr = 1'b0;
    #1;
    check("wr_err_set", 32'(bus.wr_err), 1);

    // Load 16 words without ld_last; a 17th offer must be refused
    bus.ld_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.ld_data = 12'h100 + 12'(k);
      tick();
    end
    bus.ld_data = 12'hFFF;
    #1;
    check("full_load_run", 32'(bus.run), 1);
    check("full_load_ld_ready", 32'(bus.ld_ready), 0);
    tick();
    bus.ld_valid = 1'b0;
    bus.PC = 5'd0; #1;
    check("word0_not_overwritten", 32'(bus.instruction), 32'h100);
    bus.PC = 5'd30; #1;
    check("fetch_pc30_word15", 32'(bus.instruction), 32'h10F);
    bus.PC = 5'd3; #1;
    check("fetch_pc3_word1", 32'(bus.instruction), 32'h101);
    bus.ALUOutput = 5'd4; #1;
    check("load_write_dropped", 32'(bus.datain), 0);
    bus.ALUOutput = 5'd9; #1;
    check("dmem_cleared_by_rst", 32'(bus.datain), 0);
    check("wr_err_sticky", 32'(bus.wr_err), 1);
`ifdef VSA_MEM_WRCOUNT_EN
    check("load_write_not_counted", 32'(wrCount), 0);
    bus.wr = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.ALUOutput = 5'(k);
      bus.dataout   = 5'(k + 3);
      tick();
    end
    bus.wr = 1'b0;
    #1;
    check("wr_count_saturated", 32'(wrCount), 32'hFF);
`endif

    // Reset mid-load discards the partial image
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.ld_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.ld_data = 12'hA00 + 12'(k);
      tick();
    end
    bus.ld_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    check("midload_rst_wr_err", 32'(bus.wr_err), 0);
    check("midload_rst_ld_ready", 32'(bus.ld_ready), 0);
    reset_n = 1'b1;
    bus.PC = 5'd0;
    #1;
    check("midload_rst_run", 32'(bus.run), 0);
    check("midload_rst_pc0", 32'(bus.instruction), 0);
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b1;
    bus.ld_data  = 12'h555;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    #1;
    check("reload_lp_restart", 32'(bus.instruction), 32'h555);
    bus.PC = 5'd2; #1;
    check("partial_image_discarded", 32'(bus.instruction), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
